gps_emu_scheduler: RTL and testbench

- Configuration sequencer for the multi-satellite GPS emulator datapath. It drives per-satellite doppler, gain, C/A select and global enable.
- The host stages per-satellite settings into shadow registers through a valid/ready port, then requests a commit.
- The commit is applied atomically to all satellites on the next C/A epoch boundary (programmable sample count, 1 ms nominal), so satellite changes never tear mid-code-period.
- Sits between the host register interface and the emulator's freq/gain/ca_sel/enable inputs.

---
 rtl/gps_emu_pkg.sv | 29 ++
 rtl/gps_emu_scheduler_if.sv | 35 +++
 rtl/gps_emu_scheduler_epoch_timer.sv | 37 +++
 rtl/gps_emu_scheduler.sv | 174 +++++++++++++++++
 tb/tb_gps_emu_scheduler.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/gps_emu_pkg.sv
// Shared types and constants for the GPS emulator configuration scheduler.
// Optional doppler ramp feature: GPS_EMU_DOPPLER_RAMP_EN.
package gps_emu_pkg;

   localparam int NSAT_DEFAULT = 4;
   localparam int CA_SEL_MAX   = 35;

   typedef logic [31:0] freq_t;
   typedef logic [15:0] gain_t;
   typedef logic [5:0]  ca_sel_t;

   typedef struct packed {
      freq_t   freq;
      gain_t   gain;
      ca_sel_t ca_sel;
      freq_t   rate;
   } sat_cfg_t;

   typedef enum logic {
      IDLE  = 1'b0,
      ARMED = 1'b1
   } sched_state_e;

   function automatic logic sat_in_range(input int unsigned sat,
                                         input int unsigned nsat);
      return sat < nsat;
   endfunction

endpackage

// File: rtl/gps_emu_scheduler_if.sv
// Host-side staging / commit port of the GPS emulator scheduler.
// Master is the host, slave is the scheduler.
interface gps_emu_scheduler_if
   import gps_emu_pkg::*;
#(
   parameter int NSAT = NSAT_DEFAULT
);

   localparam int SAT_W = $clog2(NSAT) + 1;

   logic             cfg_valid;
   logic             cfg_ready;
   logic [SAT_W-1:0] cfg_sat;
   freq_t            cfg_freq;
   gain_t            cfg_gain;
   ca_sel_t          cfg_ca_sel;
   freq_t            cfg_rate;
   logic             commit_req;
   logic             commit_run;
   logic             commit_ack;
   logic             cfg_err;

   modport master (
      output cfg_valid, cfg_sat, cfg_freq, cfg_gain,
      output cfg_ca_sel, cfg_rate, commit_req, commit_run,
      input  cfg_ready, commit_ack, cfg_err
   );

   modport slave (
      input  cfg_valid, cfg_sat, cfg_freq, cfg_gain,
      input  cfg_ca_sel, cfg_rate, commit_req, commit_run,
      output cfg_ready, commit_ack, cfg_err
   );

endinterface

// File: rtl/gps_emu_scheduler_epoch_timer.sv
// C/A epoch timer: free-running sample counter, end-of-epoch tick
// and a wrapping count of completed epochs.
module gps_epoch_timer #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [31:0]      i_epoch_len,
   output logic             o_tick,
   output logic [CNT_W-1:0] o_epoch_cnt
);

   logic [31:0]      r_cnt;
   logic [31:0]      w_last;
   logic [CNT_W-1:0] r_epoch_cnt;

   // A zero length behaves as a one-clock epoch.
   assign w_last = (i_epoch_len == 32'd0) ? 32'd0 : i_epoch_len - 32'd1;

   // ">=" lets a shrinking length end the epoch immediately.
   assign o_tick = (r_cnt >= w_last);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt       <= 32'd0;
         r_epoch_cnt <= '0;
      end else if (o_tick) begin
         r_cnt       <= 32'd0;
         r_epoch_cnt <= r_epoch_cnt + 1'b1;
      end else begin
         r_cnt <= r_cnt + 32'd1;
      end
   end

   assign o_epoch_cnt = r_epoch_cnt;

endmodule

// File: rtl/gps_emu_scheduler.sv
// Stages per-satellite settings in shadows and applies them atomically
// on the next C/A epoch boundary. Ramp option: GPS_EMU_DOPPLER_RAMP_EN.
module gps_emu_scheduler
   import gps_emu_pkg::*;
#(
   parameter int NSAT        = NSAT_DEFAULT,
   parameter int EPOCH_CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [31:0]            epoch_len,
   gps_emu_scheduler_if.slave     host,
   output logic                   epoch_tick,
   output logic [EPOCH_CNT_W-1:0] epoch_cnt,
   output logic                   enable,
   output freq_t   [NSAT-1:0]     freq,
   output gain_t   [NSAT-1:0]     gain,
   output ca_sel_t [NSAT-1:0]     ca_sel
);

   localparam int SAT_W = $clog2(NSAT) + 1;

   sched_state_e r_state;
   sched_state_e w_next;

   logic w_ready;
   logic w_wr;
   logic w_sat_ok;
   logic w_commit;
   logic w_tick;

   freq_t   r_sh_freq [NSAT];
   gain_t   r_sh_gain [NSAT];
   ca_sel_t r_sh_ca   [NSAT];

   freq_t   [NSAT-1:0] r_freq;
   gain_t   [NSAT-1:0] r_gain;
   ca_sel_t [NSAT-1:0] r_ca;

   logic r_run;
   logic r_enable;
   logic r_ack;
   logic r_err;

`ifdef GPS_EMU_DOPPLER_RAMP_EN
   freq_t r_sh_rate  [NSAT];
   freq_t r_rate_act [NSAT];
`else
   logic w_unused_rate;
   assign w_unused_rate = ^host.cfg_rate;
`endif

   gps_epoch_timer #(
      .CNT_W (EPOCH_CNT_W)
   ) u_timer (
      .clk         (clk),
      .reset       (reset),
      .i_epoch_len (epoch_len),
      .o_tick      (w_tick),
      .o_epoch_cnt (epoch_cnt)
   );

   assign w_wr     = host.cfg_valid && w_ready;
   assign w_sat_ok = sat_in_range(32'(host.cfg_sat), NSAT);
   assign w_commit = (r_state == ARMED) && w_tick;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Arming in a tick cycle waits for the following tick.
   always_comb begin
      w_next  = r_state;
      w_ready = 1'b0;
      unique case (r_state)
         IDLE: begin
            w_ready = 1'b1;
            if (host.commit_req) begin
               w_next = ARMED;
            end
         end
         ARMED: begin
            if (w_tick) begin
               w_next = IDLE;
            end
         end
         default: begin
            w_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NSAT; i++) begin
            r_sh_freq[i] <= '0;
            r_sh_gain[i] <= '0;
            r_sh_ca[i]   <= '0;
`ifdef GPS_EMU_DOPPLER_RAMP_EN
            r_sh_rate[i] <= '0;
`endif
         end
         r_run <= 1'b0;
         r_err <= 1'b0;
      end else begin
         if (w_wr && !w_sat_ok) begin
            r_err <= 1'b1;
         end
         for (int i = 0; i < NSAT; i++) begin
            if (w_wr && host.cfg_sat == SAT_W'(i)) begin
               r_sh_freq[i] <= host.cfg_freq;
               r_sh_gain[i] <= host.cfg_gain;
               r_sh_ca[i]   <= host.cfg_ca_sel;
`ifdef GPS_EMU_DOPPLER_RAMP_EN
               r_sh_rate[i] <= host.cfg_rate;
`endif
            end
         end
         if (w_ready && host.commit_req) begin
            r_run <= host.commit_run;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_freq   <= '0;
         r_gain   <= '0;
         r_ca     <= '0;
         r_enable <= 1'b0;
         r_ack    <= 1'b0;
`ifdef GPS_EMU_DOPPLER_RAMP_EN
         for (int i = 0; i < NSAT; i++) begin
            r_rate_act[i] <= '0;
         end
`endif
      end else begin
         r_ack <= w_commit;
         if (w_commit) begin
            for (int i = 0; i < NSAT; i++) begin
               r_freq[i] <= r_sh_freq[i];
               r_gain[i] <= r_sh_gain[i];
               r_ca[i]   <= r_sh_ca[i];
`ifdef GPS_EMU_DOPPLER_RAMP_EN
               r_rate_act[i] <= r_sh_rate[i];
`endif
            end
            r_enable <= r_run;
         end
`ifdef GPS_EMU_DOPPLER_RAMP_EN
         else if (w_tick && r_enable) begin
            for (int i = 0; i < NSAT; i++) begin
               r_freq[i] <= r_freq[i] + r_rate_act[i];
            end
         end
`endif
      end
   end

   assign host.cfg_ready  = w_ready;
   assign host.commit_ack = r_ack;
   assign host.cfg_err    = r_err;

   assign epoch_tick = w_tick;
   assign enable     = r_enable;
   assign freq       = r_freq;
   assign gain       = r_gain;
   assign ca_sel     = r_ca;

endmodule

// File: tb/tb_gps_emu_scheduler.sv
// Bench for gps_emu_scheduler: directed scenarios plus random traffic
// against a transaction-level model. Ramp checks under GPS_EMU_DOPPLER_RAMP_EN.
module tb_gps_emu_scheduler;
   import gps_emu_pkg::*;

   localparam int NSAT  = 4;
   localparam int EW    = 16;
   localparam int SAT_W = $clog2(NSAT) + 1;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [31:0]   epoch_len = 32'd10;
   logic          epoch_tick;
   logic [EW-1:0] epoch_cnt;
   logic          enable;
   freq_t   [NSAT-1:0] freq;
   gain_t   [NSAT-1:0] gain;
   ca_sel_t [NSAT-1:0] ca_sel;

   gps_emu_scheduler_if #(.NSAT(NSAT)) hif ();

   gps_emu_scheduler #(
      .NSAT        (NSAT),
      .EPOCH_CNT_W (EW)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .epoch_len  (epoch_len),
      .host       (hif),
      .epoch_tick (epoch_tick),
      .epoch_cnt  (epoch_cnt),
      .enable     (enable),
      .freq       (freq),
      .gain       (gain),
      .ca_sel     (ca_sel)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference model state
   sat_cfg_t    m_sh   [NSAT];
   freq_t       m_f    [NSAT];
   gain_t       m_g    [NSAT];
   ca_sel_t     m_c    [NSAT];
   freq_t       m_rate [NSAT];
   logic        m_en, m_ack, m_err, m_arm, m_run;
   int unsigned m_cnt;
   logic [EW-1:0] m_ecnt;

   function automatic void m_clear();
      for (int i = 0; i < NSAT; i++) begin
         m_sh[i]   = '0;
         m_f[i]    = '0;
         m_g[i]    = '0;
         m_c[i]    = '0;
         m_rate[i] = '0;
      end
      m_en = 0; m_ack = 0; m_err = 0; m_arm = 0; m_run = 0;
      m_cnt = 0; m_ecnt = '0;
   endfunction

   task automatic chk_regs(input string p);
      chk({p, "_enable"}, enable, m_en);
      chk({p, "_ack"}, hif.commit_ack, m_ack);
      chk({p, "_err"}, hif.cfg_err, m_err);
      chk({p, "_ecnt"}, epoch_cnt, m_ecnt);
      for (int i = 0; i < NSAT; i++) begin
         chk($sformatf("%s_freq%0d", p, i), freq[i], m_f[i]);
         chk($sformatf("%s_gain%0d", p, i), gain[i], m_g[i]);
         chk($sformatf("%s_ca%0d", p, i), ca_sel[i], m_c[i]);
      end
   endtask

   // One clock: drive, check combinational outputs, clock, check state.
   task automatic cyc(input logic v, input logic [SAT_W-1:0] s,
                      input sat_cfg_t c, input logic req, input logic run);
      int unsigned len;
      logic        tk;
      logic        idle_st;
      hif.cfg_valid  = v;
      hif.cfg_sat    = s;
      hif.cfg_freq   = c.freq;
      hif.cfg_gain   = c.gain;
      hif.cfg_ca_sel = c.ca_sel;
      hif.cfg_rate   = c.rate;
      hif.commit_req = req;
      hif.commit_run = run;
      #1;
      len = (epoch_len == 0) ? 1 : epoch_len;
      tk  = (m_cnt >= len - 1);
      idle_st = !m_arm;
      chk("tick", epoch_tick, tk);
      chk("ready", hif.cfg_ready, idle_st);
      m_ack = 0;
      if (m_arm && tk) begin
         for (int i = 0; i < NSAT; i++) begin
            m_f[i]    = m_sh[i].freq;
            m_g[i]    = m_sh[i].gain;
            m_c[i]    = m_sh[i].ca_sel;
            m_rate[i] = m_sh[i].rate;
         end
         m_en  = m_run;
         m_ack = 1;
         m_arm = 0;
      end
`ifdef GPS_EMU_DOPPLER_RAMP_EN
      else if (tk && m_en) begin
         for (int i = 0; i < NSAT; i++) m_f[i] = m_f[i] + m_rate[i];
      end
`endif
      if (idle_st) begin
         if (v) begin
            if (int'(s) < NSAT) m_sh[int'(s)] = c;
            else m_err = 1;
         end
         if (req) begin
            m_run = run;
            m_arm = 1;
         end
      end
      if (tk) m_ecnt = m_ecnt + 1'b1;
      m_cnt = tk ? 0 : m_cnt + 1;
      @(posedge clk);
      #1;
      hif.cfg_valid  = 0;
      hif.commit_req = 0;
      chk_regs("cyc");
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) cyc(0, '0, '0, 0, 0);
   endtask

   task automatic do_reset();
      hif.cfg_valid  = 0;
      hif.commit_req = 0;
      reset = 1;
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 0;
      m_clear();
      chk_regs("rst");
   endtask

   sat_cfg_t c;
   logic     seen;

   initial begin
      hif.cfg_valid  = 0;
      hif.cfg_sat    = '0;
      hif.cfg_freq   = '0;
      hif.cfg_gain   = '0;
      hif.cfg_ca_sel = '0;
      hif.cfg_rate   = '0;
      hif.commit_req = 0;
      hif.commit_run = 0;

      // Epoch timing
      epoch_len = 10;
      do_reset();
      chk("t1_ready", hif.cfg_ready, 1'b1);
      idle(30);
      chk("t1_ecnt", epoch_cnt, 16'd3);

      // Staged writes, commit at count 2, applied after the tick
      cyc(1, 3'd0, '{32'h1000, 16'h4000, 6'd5, 32'd0}, 0, 0);
      cyc(1, 3'd3, '{32'h0, 16'h0, 6'd35, 32'd0}, 0, 0);
      cyc(0, '0, '0, 1, 1);
      chk("t2_armed_ready", hif.cfg_ready, 1'b0);
      idle(6);
      chk("t2_hold_freq0", freq[0], 32'h0);
      idle(1);
      chk("t2_freq0", freq[0], 32'h1000);
      chk("t2_ca3", ca_sel[3], 6'd35);
      chk("t2_enable", enable, 1'b1);
      chk("t2_ack", hif.commit_ack, 1'b1);
      idle(1);
      chk("t2_ack_single", hif.commit_ack, 1'b0);

      // Commit requested in a tick cycle waits a full epoch
      idle(8);
      cyc(1, 3'd1, '{32'h2222, 16'h1, 6'd7, 32'd0}, 1, 1);
      idle(9);
      chk("t3_notyet", freq[1], 32'h0);
      idle(1);
      chk("t3_freq1", freq[1], 32'h2222);
      chk("t3_ack", hif.commit_ack, 1'b1);

      // Out-of-range satellite index
      cyc(1, 3'd4, '{32'hdead, 16'hbeef, 6'd9, 32'd0}, 0, 0);
      chk("t4_err", hif.cfg_err, 1'b1);
      idle(5);
      chk("t4_err_sticky", hif.cfg_err, 1'b1);
      do_reset();
      chk("t4_err_clr", hif.cfg_err, 1'b0);

      // Reset while armed drops the commit
      cyc(1, 3'd2, '{32'h77, 16'h2, 6'd3, 32'd0}, 1, 1);
      idle(3);
      do_reset();
      idle(12);
      chk("t5_freq2_zero", freq[2], 32'h0);
      cyc(1, 3'd2, '{32'h55, 16'h2, 6'd3, 32'd0}, 1, 1);
      seen = 0;
      for (int n = 0; n < 20 && !seen; n++) begin
         idle(1);
         if (hif.commit_ack) seen = 1;
      end
      chk("t5_ack_seen", seen, 1'b1);
      chk("t5_freq2", freq[2], 32'h55);

`ifdef GPS_EMU_DOPPLER_RAMP_EN
      do_reset();
      cyc(1, 3'd0, '{32'hFFFFFFF0, 16'h1, 6'd1, 32'h10}, 1, 1);
      idle(9);
      chk("t6_load", freq[0], 32'hFFFFFFF0);
      idle(10);
      chk("t6_wrap", freq[0], 32'h0);
      idle(10);
      chk("t6_r1", freq[0], 32'h10);
      idle(10);
      chk("t6_r2", freq[0], 32'h20);
      cyc(0, '0, '0, 1, 0);
      idle(29);
      chk("t6_hold", freq[0], 32'hFFFFFFF0);
      chk("t6_en0", enable, 1'b0);
`endif

      // Random traffic, including length changes and resets
      do_reset();
      for (int k = 0; k < 800; k++) begin
         if ($urandom_range(0, 39) == 0) epoch_len = $urandom_range(0, 12);
         if ($urandom_range(0, 299) == 0) begin
            do_reset();
         end else begin
            c.freq   = $urandom;
            c.gain   = 16'($urandom);
            c.ca_sel = 6'($urandom_range(0, CA_SEL_MAX));
            c.rate   = $urandom_range(0, 3) == 0 ? $urandom : 32'($urandom_range(0, 255));
            cyc($urandom_range(0, 2) == 0,
                SAT_W'($urandom_range(0, 5)), c,
                $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
